inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64, is the largest accepted program length in 32-bit words; legal range is 1..64.
REQ-002 Parameter ADDR_W, default 8, is the instruction-memory byte-address width and matches the CPU program counter.
REQ-003 clk_Loader  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 rst_Loader_n  input  1  is the reset, which is asynchronous and active-low.
REQ-005 byte_in  input  8  is the serial program byte from the host link.
REQ-006 byte_valid  input  1  indicates that byte_in holds a valid byte.
REQ-007 byte_ready  output  1  indicates that the loader accepts a byte this cycle.
REQ-008 imem_we  output  1  is the instruction-memory write strobe.
REQ-009 imem_addr  output  ADDR_W  is the instruction-memory byte address and is always word-aligned.
REQ-010 imem_data  output  32  is the instruction word to write.
REQ-011 cpu_run  output  1  releases the CPU pipeline when high; when low, the CPU is held.
REQ-012 load_err  output  1  indicates a load failure, set by a bad length or a bad checksum.
REQ-013 words_loaded  output  7  is the number of words written so far.

Function
REQ-014 A byte transfer occurs only in a cycle where byte_valid=1 and byte_ready=1.
REQ-015 The stream format is 1 length byte N, then N×4 payload bytes, then 1 checksum byte.
REQ-016 The loader SHALL implement the states COUNT, BYTES, WRITE, CHECK, DONE and ERR.
REQ-017 byte_ready SHALL be 1 in COUNT, BYTES and CHECK, and 0 in WRITE, DONE and ERR.
REQ-018 COUNT: on a transfer, the loader latches N. If N=0 or N>MAX_WORDS, it goes to ERR; otherwise it goes to BYTES.
REQ-019 BYTES: each transfer shifts byte_in into the word, big-endian, so the first byte becomes bits [31:24].
REQ-020 BYTES: the 4th transfer moves the loader to WRITE in the following cycle.
REQ-021 WRITE: the state lasts exactly 1 cycle, with imem_we=1, imem_data equal to the assembled word, and imem_addr equal to the current address.
REQ-022 WRITE: the address SHALL then increment by 4 and words_loaded SHALL increment by 1.
REQ-023 WRITE exits to BYTES if words_loaded after the increment is less than N; otherwise it exits to CHECK.
REQ-024 imem_we SHALL be 0 in every state except WRITE.
REQ-025 The write address starts at 0 and never wraps, because MAX_WORDS×4 ≤ 2^ADDR_W.
REQ-026 The running checksum is the XOR of the length byte and every payload byte.
REQ-027 CHECK: on a transfer, if byte_in equals the running checksum, the loader goes to DONE; otherwise it goes to ERR.
REQ-028 DONE: cpu_run=1 from the first cycle in DONE, and DONE is held until reset.
REQ-029 ERR: load_err=1 and cpu_run=0, and ERR is held until reset.
REQ-030 byte_valid is ignored whenever byte_ready=0, and no byte is consumed.
REQ-031 The latency from the 4th byte of a word being accepted to imem_we=1 is 1 cycle.
REQ-032 The minimum time per word is 5 cycles: 4 accept cycles plus 1 write cycle.
REQ-033 The total minimum load time is 1 + 5N + 1 cycles, then DONE.
REQ-034 byte_valid may be deasserted mid-word; the partial word and the byte count are retained, with no timeout.
REQ-035 Words already written before a checksum failure are not undone, but cpu_run never asserts in that case.

Reset
REQ-036 Assertion of rst_Loader_n=0 SHALL force state=COUNT, address=0, words_loaded=0, checksum=0, assembled word=0 and N=0 immediately, without waiting for a clock edge.
REQ-037 Reset output values SHALL be: byte_ready=1, imem_we=0, imem_addr=0, imem_data=0, cpu_run=0, load_err=0, words_loaded=0.
REQ-038 A reset during any state, including mid-word, DONE or ERR, SHALL abort the load, drop cpu_run in the same cycle, and restart at COUNT.
REQ-039 Release of reset SHALL be synchronised internally so that the first transfer can occur no earlier than the 2nd rising edge after deassertion.

Verification
REQ-040 Send N=01, bytes 20 08 00 05, checksum 2C: one imem_we pulse with addr=00 and data=0x20080005, then cpu_run=1 and load_err=0.
REQ-041 Send N=02 with words 0x8C010004 and 0x00221820 and the correct checksum: writes at addr 00 then 04, words_loaded=2, cpu_run=1.
REQ-042 Send N=00: the loader goes to ERR on the next cycle, with load_err=1, byte_ready=0 and no imem_we.
REQ-043 Send N=01, bytes 20 08 00 05, checksum 00: one write occurs, then load_err=1 and cpu_run stays 0.
REQ-044 Send N=02 and assert reset after 6 payload bytes: after reset all outputs hold their reset values, and a fresh N=01 load completes with addr=00.
REQ-045 Load with byte_valid toggled randomly and with byte_valid held high during WRITE: data is identical to the back-to-back load, and no byte is lost or duplicated.

Source files
------------

// File: rtl/inst_loader.sv
// Serial program loader: takes a length byte, N big-endian payload words and a
// checksum byte from the host link, fills instruction memory, then releases the CPU.
module inst_loader #(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 8
) (
  input  logic              clk_Loader,
  input  logic              rst_Loader_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              cpu_run,
  output logic              load_err,
  output logic [6:0]        words_loaded
);

  typedef enum logic [2:0] {COUNT, BYTES, WRITE, CHECK, DONE, ERR} state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        words_q, words_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        byteCnt_q, byteCnt_d;
  logic [1:0]        sync_q;
  logic              readyState;
  logic              xfer;

  always_ff @(posedge clk_Loader or negedge rst_Loader_n) begin
    if (!rst_Loader_n) sync_q <= '0;
    else               sync_q <= {sync_q[0], 1'b1};
  end

  // No transfer until reset release has crossed both sync stages; while reset is
  // held the port still advertises the idle COUNT readiness.
  assign readyState = (state_q == COUNT) || (state_q == BYTES) || (state_q == CHECK);
  assign byte_ready = readyState && (sync_q[1] || !rst_Loader_n);
  assign xfer       = byte_valid && byte_ready;

  always_ff @(posedge clk_Loader or negedge rst_Loader_n) begin
    if (!rst_Loader_n) begin
      state_q   <= COUNT;
      len_q     <= '0;
      word_q    <= '0;
      addr_q    <= '0;
      words_q   <= '0;
      csum_q    <= '0;
      byteCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      csum_q    <= csum_d;
      byteCnt_q <= byteCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    word_d    = word_q;
    addr_d    = addr_q;
    words_d   = words_q;
    csum_d    = csum_q;
    byteCnt_d = byteCnt_q;
    case (state_q)
      COUNT: begin
        if (xfer) begin
          len_d  = byte_in;
          csum_d = byte_in;
          if (byte_in == 8'd0 || int'(byte_in) > MAX_WORDS) state_d = ERR;
          else                                              state_d = BYTES;
        end
      end
      BYTES: begin
        if (xfer) begin
          word_d    = {word_q[23:0], byte_in};
          csum_d    = csum_q ^ byte_in;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        words_d = words_q + 7'd1;
        // Compare against the post-increment count in 8 bits to match N's width.
        if (({1'b0, words_q} + 8'd1) < len_q) state_d = BYTES;
        else                                  state_d = CHECK;
      end
      CHECK: begin
        if (xfer) begin
          if (byte_in == csum_q) state_d = DONE;
          else                   state_d = ERR;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = COUNT;
    endcase
  end

  assign imem_we      = (state_q == WRITE);
  assign imem_addr    = addr_q;
  assign imem_data    = word_q;
  assign cpu_run      = (state_q == DONE);
  assign load_err     = (state_q == ERR);
  assign words_loaded = words_q;

endmodule
